// File: rtl/lsu_load_req.sv
// lsu_load_req: issues loads to a 2-cycle dcache, buffers responses in order.
// Ports: clk, rst (async, active-high); req_valid/req_addr/req_ready load
//   request; flush drops all outstanding loads; cache_addr/cache_data dcache
//   side; resp_valid/resp_data/resp_err/resp_ready response side.
// Optional: define LSU_MISALIGN_CHECK_EN to flag req_addr[1:0]!=0 as errors.
module lsu_load_req #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   input  logic        flush,
   output logic [31:0] cache_addr,
   input  logic [31:0] cache_data,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   input  logic        resp_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = CW + 1;

   logic          r_v1;
   logic          r_v2;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_mem [FIFO_DEPTH];

   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic [OW-1:0] w_occ;
   logic [31:0]   w_push_data;

   assign cache_addr = req_addr;

   // Slots already promised: buffered entries plus loads still in the
   // dcache pipe, so a push can never find the FIFO full.
   assign w_occ = {1'b0, r_count} + OW'(r_v1) + OW'(r_v2);

   assign req_ready  = (w_occ < OW'(FIFO_DEPTH)) && !flush;
   assign w_accept   = req_valid && req_ready;
   assign w_push     = r_v2 && !flush;
   assign resp_valid = (r_count != '0);
   assign w_pop      = resp_valid && resp_ready && !flush;

`ifdef LSU_MISALIGN_CHECK_EN
   logic                  r_e1;
   logic                  r_e2;
   logic [FIFO_DEPTH-1:0] r_emem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e1 <= 1'b0;
         r_e2 <= 1'b0;
      end else if (flush) begin
         r_e1 <= 1'b0;
         r_e2 <= 1'b0;
      end else begin
         r_e1 <= w_accept && (req_addr[1:0] != 2'b00);
         r_e2 <= r_e1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_emem[r_wptr] <= r_e2;
      end
   end

   // A faulting load returns zero data rather than whatever the cache read.
   assign w_push_data = r_e2 ? 32'h0 : cache_data;
   assign resp_err    = resp_valid && r_emem[r_rptr];
`else
   assign w_push_data = cache_data;
   assign resp_err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_v1 <= w_accept;
         r_v2 <= r_v1;
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: reads are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_push_data;
      end
   end

   assign resp_data = resp_valid ? r_mem[r_rptr] : 32'h0;

endmodule

// File: tb/tb_lsu_load_req.sv
// tb_lsu_load_req: directed vectors and corner sequences for lsu_load_req.
// The dcache model returns addr + 0x8000_0000 two cycles after the address.
module tb_lsu_load_req;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        flush;
   logic [31:0] cache_addr;
   logic [31:0] cache_data;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        resp_ready;

   int checks   = 0;
   int failures = 0;

   logic [31:0] d1 = 32'h0;
   logic [31:0] d2 = 32'h0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      d1 <= cache_addr + 32'h8000_0000;
      d2 <= d1;
   end
   assign cache_data = d2;

   lsu_load_req #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .flush      (flush),
      .cache_addr (cache_addr),
      .cache_data (cache_data),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .resp_ready (resp_ready)
   );

   typedef struct {
      logic        rv;
      logic [31:0] addr;
      logic        rr;
      logic        fl;
      logic        e_ready;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_err;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [31:0] a,
                        input logic rr, input logic fl);
      @(negedge clk);
      req_valid  = rv;
      req_addr   = a;
      resp_ready = rr;
      flush      = fl;
      #1;
   endtask

   task automatic chk_out(input string tag, input logic rdy,
                          input logic v, input logic [31:0] d,
                          input logic e);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(v));
      chk({tag, ".resp_data"}, resp_data, d);
      chk({tag, ".resp_err"}, 32'(resp_err), 32'(e));
   endtask

   task automatic set_vec(input int i, input logic rv, input logic [31:0] a,
                          input logic rdy, input logic v,
                          input logic [31:0] d);
      tbl[i].rv      = rv;
      tbl[i].addr    = a;
      tbl[i].rr      = 1'b1;
      tbl[i].fl      = 1'b0;
      tbl[i].e_ready = rdy;
      tbl[i].e_valid = v;
      tbl[i].e_data  = d;
      tbl[i].e_err   = 1'b0;
   endtask

   initial begin
      int acc;
      logic exp_rdy;

      // single load, then a 5-deep back-to-back burst
      set_vec(0,  1, 32'h10,  1, 0, 32'h0);
      set_vec(1,  0, 32'h0,   1, 0, 32'h0);
      set_vec(2,  0, 32'h0,   1, 0, 32'h0);
      set_vec(3,  0, 32'h0,   1, 1, 32'h8000_0010);
      set_vec(4,  0, 32'h0,   1, 0, 32'h0);
      set_vec(5,  1, 32'h100, 1, 0, 32'h0);
      set_vec(6,  1, 32'h104, 1, 0, 32'h0);
      set_vec(7,  1, 32'h108, 1, 0, 32'h0);
      set_vec(8,  1, 32'h10C, 1, 1, 32'h8000_0100);
      set_vec(9,  1, 32'h110, 1, 1, 32'h8000_0104);
      set_vec(10, 0, 32'h0,   1, 1, 32'h8000_0108);
      set_vec(11, 0, 32'h0,   1, 1, 32'h8000_010C);
      set_vec(12, 0, 32'h0,   1, 1, 32'h8000_0110);
      set_vec(13, 0, 32'h0,   1, 0, 32'h0);

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = 32'h0;
      flush      = 1'b0;
      resp_ready = 1'b1;
      #2;
      chk_out("reset", 1, 0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rv, tbl[i].addr, tbl[i].rr, tbl[i].fl);
         chk_out($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_valid,
                 tbl[i].e_data, tbl[i].e_err);
         chk($sformatf("vec%0d.cache_addr", i), cache_addr, tbl[i].addr);
      end

      // backpressure: only four loads fit, then drain in order
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'h200 + 32'(4 * i), 0, 0);
         exp_rdy = (i < 4);
         chk($sformatf("bp%0d.req_ready", i), 32'(req_ready), 32'(exp_rdy));
         if (req_ready) acc++;
      end
      chk("bp.accepted", 32'(acc), 32'd4);
      for (int k = 0; k < 4; k++) begin
         drive(0, 32'h0, 1, 0);
         chk($sformatf("bp_drain%0d.valid", k), 32'(resp_valid), 32'd1);
         chk($sformatf("bp_drain%0d.data", k), resp_data,
             32'h8000_0200 + 32'(4 * k));
      end
      drive(0, 32'h0, 1, 0);
      chk_out("bp_done", 1, 0, 32'h0, 0);

      // flush with one entry buffered and one load in flight
      drive(1, 32'h400, 0, 0);
      drive(1, 32'h404, 0, 0);
      drive(0, 32'h0, 0, 0);
      drive(1, 32'h999, 0, 1);
      chk_out("flush_cyc", 0, 1, 32'h8000_0400, 0);
      for (int k = 0; k < 5; k++) begin
         drive(0, 32'h0, 1, 0);
         chk_out($sformatf("post_flush%0d", k), 1, 0, 32'h0, 0);
      end
      drive(1, 32'h20, 1, 0);
      drive(0, 32'h0, 1, 0);
      drive(0, 32'h0, 1, 0);
      chk("flush_new.pre", 32'(resp_valid), 32'd0);
      drive(0, 32'h0, 1, 0);
      chk_out("flush_new", 1, 1, 32'h8000_0020, 0);

      // asynchronous reset in the middle of a burst
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'h300 + 32'(4 * k), 1, 0);
      end
      chk_out("prerst", 1, 1, 32'h8000_0300, 0);
      #1;
      rst       = 1'b1;
      req_valid = 1'b0;
      #1;
      chk_out("in_rst", 1, 0, 32'h0, 0);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(0, 32'h0, 1, 0);
         chk_out($sformatf("post_rst%0d", k), 1, 0, 32'h0, 0);
      end

      // misaligned access handling
      drive(1, 32'h40, 1, 0);
      drive(1, 32'h41, 1, 0);
      drive(1, 32'h44, 1, 0);
      drive(0, 32'h0, 1, 0);
      chk_out("mis0", 1, 1, 32'h8000_0040, 0);
      drive(0, 32'h0, 1, 0);
`ifdef LSU_MISALIGN_CHECK_EN
      chk_out("mis1", 1, 1, 32'h0, 1);
`else
      chk_out("mis1", 1, 1, 32'h8000_0041, 0);
`endif
      drive(0, 32'h0, 1, 0);
      chk_out("mis2", 1, 1, 32'h8000_0044, 0);
      drive(0, 32'h0, 1, 0);
      chk_out("mis_end", 1, 0, 32'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_load_req.md
LSU_LOAD_REQ -- requirements
Module: lsu_load_req

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, response buffer entries; power of two, >=4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  pipeline presents a load request.
REQ-005 req_addr  input  32  byte address of load.
REQ-006 req_ready  output  1  request accepted when req_valid&&req_ready at a rising edge.
REQ-007 flush  input  1  synchronous discard of all outstanding loads.
REQ-008 cache_addr  output  32  address driven to dcache; combinational copy of req_addr.
REQ-009 cache_data  input  32  dcache read data; valid exactly 2 cycles after the address was presented.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_data  output  32  load data for head response.
REQ-012 resp_err  output  1  head response is a misaligned-access error.
REQ-013 resp_ready  input  1  consumer takes response when resp_valid&&resp_ready at a rising edge.

Function
REQ-014 Accept in cycle T SHALL set in-flight stage bit v1 for cycle T+1, shifting to v2 for cycle T+2.
REQ-015 When v2=1, cache_data (with its err bit) SHALL be pushed into the response FIFO at the edge ending cycle T+2; resp_valid earliest in cycle T+3 (3-cycle load latency).
REQ-016 req_ready SHALL equal (count + v1 + v2 < FIFO_DEPTH) && !flush; count is current FIFO occupancy.
REQ-017 The FIFO SHALL never overflow; this is guaranteed by REQ-016, and no push is ever dropped.
REQ-018 With resp_ready held 1, one request per cycle SHALL be sustained indefinitely.
REQ-019 Responses SHALL return in request order, including error responses.
REQ-020 resp_data/resp_err SHALL be the FIFO head; undefined bits are not allowed: when empty, resp_valid=0 and resp_data=0, resp_err=0.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pop from full and push into empty-with-pop are both legal.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-023 flush=1 SHALL clear v1, v2, err stage bits, pointers and count at that edge; any accept or push in the same cycle is discarded; a pop in the same cycle is ignored.
REQ-024 cache_addr SHALL follow req_addr every cycle regardless of accept; data for unaccepted cycles is ignored.

Reset
REQ-025 rst=1 SHALL immediately clear v1, v2, err stage bits, FIFO pointers and count, independent of clk.
REQ-026 During and after reset until the next accept: req_ready=1 (when !flush), resp_valid=0, resp_data=0, resp_err=0.
REQ-027 Reset asserted mid-operation SHALL abandon all in-flight loads; no response for them ever appears.

Configuration
REQ-028 Macro LSU_MISALIGN_CHECK_EN: when defined, an accepted request with req_addr[1:0]!=0 SHALL mark its stage err=1, and its response SHALL carry resp_err=1, resp_data=0, same latency and ordering.
REQ-029 Without LSU_MISALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored for checking, resp_err SHALL be tied 0, and the err stage logic SHALL be absent.

Verification (bench dcache model: data = registered-twice (addr + 0x8000_0000))
REQ-030 Single load addr 0x0000_0010 accepted cycle 0, resp_ready=1 -> resp_valid cycle 3, resp_data 0x8000_0010, resp_err 0.
REQ-031 Back-to-back loads 0x100,0x104,0x108,0x10C,0x110, resp_ready=1 -> req_ready never drops; responses 0x8000_0100..0x8000_0110 on consecutive cycles 3..7.
REQ-032 resp_ready=0, continuous requests -> exactly 4 accepted, req_ready=0 thereafter; raise resp_ready -> 4 responses in order, then acceptance resumes.
REQ-033 Flush in the cycle after 2 accepts with 1 entry buffered -> resp_valid=0 next cycle; no stale responses ever; new load 0x20 -> 0x8000_0020 at +3.
REQ-034 rst pulsed asynchronously mid-burst -> outputs reset immediately; no responses for pre-reset loads.
REQ-035 With LSU_MISALIGN_CHECK_EN: loads 0x40, 0x41, 0x44 -> responses (0x8000_0040,0), (0,1), (0x8000_0044,0) in order.
